// File: rtl/risky_pkg.sv
// Shared types and defaults for the unified memory arbiter.
// The optional MEM_ARB_RR_EN build macro (see mem_arb_pick) switches
// tie-breaking from fixed data-over-fetch priority to round-robin.
package risky_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_e;

    localparam int DEFAULT_MEM_LATENCY = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the shared
// single-port memory. The master modport is the arbiter's view; the slave
// modport is the view of the surrounding pipeline and memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [BE_W-1:0]   dm_be_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [DATA_W-1:0] dm_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport slave (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data requesters.
// Default build: data always beats fetch on a tie.
// With MEM_ARB_RR_EN defined: a tie goes to the port that was not granted last.
module mem_arb_pick
    import risky_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  arb_owner_e last_owner,
    output arb_owner_e winner
);

`ifdef MEM_ARB_RR_EN
    // On a tie alternate away from the previous owner; otherwise the lone requester wins.
    always_comb begin
        winner = OWN_IF;
        if (if_req && dm_req) begin
            winner = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
        end else if (dm_req) begin
            winner = OWN_DM;
        end
    end
`else
    logic unused_pick;
    assign unused_pick = if_req ^ (last_owner == OWN_DM);

    // Data port has fixed priority; fetch wins only when data is idle.
    always_comb begin
        winner = OWN_IF;
        if (dm_req) begin
            winner = OWN_DM;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Unified memory arbiter: shares one fixed-latency single-port memory between
// the fetch stage (reads) and the mem-access stage (reads and writes), with a
// single transaction in flight. Build macro MEM_ARB_RR_EN selects round-robin
// tie-breaking and adds a last-owner flop; without it data beats fetch.
module mem_arbiter
    import risky_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam int BE_W = DATA_W / 8;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    arb_owner_e        winner;
    arb_owner_e        last_owner;
    logic              txn_we_q, txn_we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic              any_req;
    logic              can_grant;
    logic              if_gnt;
    logic              dm_gnt;
    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign any_req = bus.if_req_i | bus.dm_req_i;

    mem_arb_pick u_pick (
        .if_req     (bus.if_req_i),
        .dm_req     (bus.dm_req_i),
        .last_owner (last_owner),
        .winner     (winner)
    );

`ifdef MEM_ARB_RR_EN
    arb_owner_e last_owner_q, last_owner_d;

    // Remember which port received the most recent grant for tie-breaking.
    always_comb begin
        last_owner_d = last_owner_q;
        if (if_gnt) begin
            last_owner_d = OWN_IF;
        end else if (dm_gnt) begin
            last_owner_d = OWN_DM;
        end
    end

    // Last-owner register starts at fetch so the first tie goes to data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= OWN_IF;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_IF;
`endif

    // Next-state, grant and memory-strobe logic; RESP doubles as an IDLE cycle.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        txn_we_d   = txn_we_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        can_grant  = 1'b0;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            ARB_IDLE: begin
                can_grant = 1'b1;
            end
            ARB_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (!txn_we_q) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_d = bus.mem_rdata_i;
                        end else begin
                            dm_rdata_d = bus.mem_rdata_i;
                        end
                    end
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                can_grant = 1'b1;
                state_d   = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (can_grant && any_req && !rst) begin
            mem_req = 1'b1;
            owner_d = winner;
            cnt_d   = CNT_LOAD;
            state_d = ARB_WAIT;
            if (winner == OWN_DM) begin
                dm_gnt    = 1'b1;
                mem_we    = bus.dm_we_i;
                mem_be    = bus.dm_be_i;
                mem_addr  = bus.dm_addr_i;
                mem_wdata = bus.dm_wdata_i;
                txn_we_d  = bus.dm_we_i;
            end else begin
                if_gnt    = 1'b1;
                mem_be    = '1;
                mem_addr  = bus.if_addr_i;
                txn_we_d  = 1'b0;
            end
        end
    end

    // State, ownership, latency counter and per-port read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            txn_we_q   <= 1'b0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            txn_we_q   <= txn_we_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.dm_gnt_o    = dm_gnt;
    assign bus.if_rvalid_o = (state_q == ARB_RESP) && (owner_q == OWN_IF);
    assign bus.dm_rvalid_o = (state_q == ARB_RESP) && (owner_q == OWN_DM);
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_be_o    = mem_be;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;

    if_req_held: assert property (@(posedge clk) disable iff (rst)
        (bus.if_req_i && !if_gnt) |=> bus.if_req_i);

    dm_req_held: assert property (@(posedge clk) disable iff (rst)
        (bus.dm_req_i && !dm_gnt) |=> bus.dm_req_i);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A transaction-level model predicts
// grants, strobes, completions and read data every cycle; directed scenarios
// add literal expectations. Honours MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;
    import risky_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LAT    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(1)) u_dut_l1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] resp    [int];

    bit          m_pending = 1'b0;
    arb_owner_e  m_owner   = OWN_IF;
    arb_owner_e  m_last    = OWN_IF;
    bit          m_we      = 1'b0;
    int          m_cap     = 0;
    int          m_rv      = 0;
    int          m_free    = 0;
    logic [31:0] m_rd [2];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic arb_owner_e modelPick(input bit ifr, input bit dmr, input arb_owner_e last);
`ifdef MEM_ARB_RR_EN
        if (ifr && dmr) return (last == OWN_DM) ? OWN_IF : OWN_DM;
`endif
        if (dmr) return OWN_DM;
        return OWN_IF;
    endfunction

    // Memory return path: data appears exactly LAT cycles after the strobe, noise otherwise.
    always @(posedge clk) begin
        #1;
        if (resp.exists(cyc)) begin
            bus.mem_rdata_i = resp[cyc];
            resp.delete(cyc);
        end else begin
            bus.mem_rdata_i = $urandom;
        end
    end

    // Per-cycle comparison against the transaction-level model.
    always @(negedge clk) begin : compare_proc
        bit          free;
        bit          e_if_gnt, e_dm_gnt;
        arb_owner_e  win;
        logic [31:0] cur;
        if (rst) begin
            checkOutput("rst_if_gnt",    32'(bus.if_gnt_o),    32'd0);
            checkOutput("rst_dm_gnt",    32'(bus.dm_gnt_o),    32'd0);
            checkOutput("rst_mem_req",   32'(bus.mem_req_o),   32'd0);
            checkOutput("rst_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
            checkOutput("rst_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd0);
            checkOutput("rst_if_rdata",  bus.if_rdata_o,       32'd0);
            checkOutput("rst_dm_rdata",  bus.dm_rdata_o,       32'd0);
            m_pending = 1'b0;
            m_last    = OWN_IF;
            m_free    = 0;
            m_rd[0]   = '0;
            m_rd[1]   = '0;
        end else begin
            free     = (cyc >= m_free);
            win      = modelPick(bus.if_req_i, bus.dm_req_i, m_last);
            e_if_gnt = free && bus.if_req_i && (win == OWN_IF);
            e_dm_gnt = free && bus.dm_req_i && (win == OWN_DM);
            checkOutput("if_gnt",    32'(bus.if_gnt_o),  32'(e_if_gnt));
            checkOutput("dm_gnt",    32'(bus.dm_gnt_o),  32'(e_dm_gnt));
            checkOutput("mem_req",   32'(bus.mem_req_o), 32'(e_if_gnt | e_dm_gnt));
            checkOutput("if_rvalid", 32'(bus.if_rvalid_o), 32'(m_pending && cyc == m_rv && m_owner == OWN_IF));
            checkOutput("dm_rvalid", 32'(bus.dm_rvalid_o), 32'(m_pending && cyc == m_rv && m_owner == OWN_DM));
            checkOutput("if_rdata",  bus.if_rdata_o, m_rd[0]);
            checkOutput("dm_rdata",  bus.dm_rdata_o, m_rd[1]);

            if (m_pending && cyc == m_cap && !m_we) m_rd[int'(m_owner)] = bus.mem_rdata_i;
            if (m_pending && cyc == m_rv) m_pending = 1'b0;

            if (e_if_gnt || e_dm_gnt) begin
                if (e_dm_gnt) begin
                    checkOutput("mem_we",   32'(bus.mem_we_o), 32'(bus.dm_we_i));
                    checkOutput("mem_addr", bus.mem_addr_o, bus.dm_addr_i);
                    if (bus.dm_we_i) begin
                        checkOutput("mem_be",    32'(bus.mem_be_o), 32'(bus.dm_be_i));
                        checkOutput("mem_wdata", bus.mem_wdata_o,   bus.dm_wdata_i);
                    end
                end else begin
                    checkOutput("mem_we",   32'(bus.mem_we_o), 32'd0);
                    checkOutput("mem_addr", bus.mem_addr_o, bus.if_addr_i);
                end
                m_pending = 1'b1;
                m_owner   = win;
                m_we      = e_dm_gnt && bus.dm_we_i;
                m_cap     = cyc + LAT;
                m_rv      = cyc + LAT + 1;
                m_free    = cyc + LAT + 1;
                m_last    = win;
            end

            if (bus.mem_req_o) begin
                if (bus.mem_we_o) begin
                    cur = memRead(bus.mem_addr_o);
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_be_o[b]) cur[8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
                    mem_arr[bus.mem_addr_o] = cur;
                end else begin
                    resp[cyc + LAT] = memRead(bus.mem_addr_o);
                end
            end
        end
    end

    task automatic applyStimulus(input bit is_if, input bit we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata, output int gnt_cyc);
        if (is_if) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = addr;
        end else begin
            bus.dm_req_i   = 1'b1;
            bus.dm_we_i    = we;
            bus.dm_be_i    = be;
            bus.dm_addr_i  = addr;
            bus.dm_wdata_i = wdata;
        end
        gnt_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((is_if && bus.if_gnt_o) || (!is_if && bus.dm_gnt_o)) begin
                gnt_cyc = cyc;
                checkOutput("mem_req_at_gnt",  32'(bus.mem_req_o), 32'd1);
                checkOutput("mem_addr_at_gnt", bus.mem_addr_o, addr);
                if (!is_if) begin
                    checkOutput("mem_we_at_gnt", 32'(bus.mem_we_o), 32'(we));
                    if (we) checkOutput("mem_be_at_gnt", 32'(bus.mem_be_o), 32'(be));
                end
                break;
            end
        end
        if (gnt_cyc < 0) timeoutFail("grant_wait");
        @(posedge clk);
        #1;
        if (is_if) bus.if_req_i = 1'b0;
        else       bus.dm_req_i = 1'b0;
    endtask

    task automatic waitRvalid(input bit is_if, output int rv_cyc);
        rv_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((is_if && bus.if_rvalid_o) || (!is_if && bus.dm_rvalid_o)) begin
                rv_cyc = cyc;
                break;
            end
        end
        if (rv_cyc < 0) timeoutFail("rvalid_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g, r, g1, g2, gi, ri, r2, start, rvcount;
        int gl[$];
        logic [31:0] dm_before;

        mem_arr[32'h10]  = 32'h0013_0093;
        mem_arr[32'h20]  = 32'h0040_0113;
        mem_arr[32'h40]  = 32'h0080_0193;
        mem_arr[32'h100] = 32'hCAFE_F00D;
        mem_arr[32'h104] = 32'h1234_0104;
        mem_arr[32'h200] = 32'h1111_2222;

        bus.if_req_i = 0; bus.if_addr_i = 0;
        bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_be_i = 0; bus.dm_addr_i = 0; bus.dm_wdata_i = 0;
        bus.mem_rdata_i = 0;
        bus1.if_req_i = 0; bus1.if_addr_i = 0;
        bus1.dm_req_i = 0; bus1.dm_we_i = 0; bus1.dm_be_i = 0; bus1.dm_addr_i = 0; bus1.dm_wdata_i = 0;
        bus1.mem_rdata_i = 0;
        rst = 1'b1;

        idleCycles(3);
        checkOutput("reset_if_rdata", bus.if_rdata_o, 32'd0);
        checkOutput("reset_state",    32'(u_dut.state_q), 32'(ARB_IDLE));
        rst = 1'b0;
        idleCycles(2);

        $display("[TB] fetch read 0x10");
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, g);
        waitRvalid(1'b1, r);
        checkOutput("if_read_latency", 32'(r - g), 32'd3);
        checkOutput("if_read_data",    bus.if_rdata_o, 32'h0013_0093);
        idleCycles(2);

        $display("[TB] simultaneous fetch and data requests");
        fork
            begin applyStimulus(1'b0, 1'b0, 4'h0, 32'h100, 32'h0, g1); waitRvalid(1'b0, r2); end
            begin applyStimulus(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, gi); waitRvalid(1'b1, ri); end
        join
        checkOutput("tie_if_after_dm",  32'(gi - g1), 32'd3);
        checkOutput("tie_if_rvalid",    32'(ri - g1), 32'd6);
        checkOutput("tie_dm_rvalid",    32'(r2 - g1), 32'd3);
        checkOutput("tie_dm_rdata",     bus.dm_rdata_o, 32'hCAFE_F00D);
        checkOutput("tie_if_rdata",     bus.if_rdata_o, 32'h0040_0113);
        idleCycles(2);

        $display("[TB] second tie in response cycle");
        fork
            begin
                applyStimulus(1'b0, 1'b0, 4'h0, 32'h100, 32'h0, g1);
                applyStimulus(1'b0, 1'b0, 4'h0, 32'h104, 32'h0, g2);
                waitRvalid(1'b0, r2);
            end
            begin
                idleCycles(1);
                applyStimulus(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, gi);
                waitRvalid(1'b1, ri);
            end
        join
`ifdef MEM_ARB_RR_EN
        checkOutput("tie2_if_first", 32'(gi - g1), 32'd3);
        checkOutput("tie2_dm_next",  32'(g2 - g1), 32'd6);
`else
        checkOutput("tie2_dm_first", 32'(g2 - g1), 32'd3);
        checkOutput("tie2_if_next",  32'(gi - g1), 32'd6);
`endif
        checkOutput("tie2_dm_rdata", bus.dm_rdata_o, 32'h1234_0104);
        idleCycles(2);

        $display("[TB] data write 0x200");
        dm_before = bus.dm_rdata_o;
        applyStimulus(1'b0, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF, g);
        waitRvalid(1'b0, r);
        checkOutput("write_latency",   32'(r - g), 32'd3);
        checkOutput("write_keeps_rd",  bus.dm_rdata_o, 32'h1234_0104);
        checkOutput("write_keeps_rd2", bus.dm_rdata_o, dm_before);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h200, 32'h0, g);
        waitRvalid(1'b0, r);
        checkOutput("readback_merged", bus.dm_rdata_o, 32'h1111_BEEF);
        idleCycles(2);

        $display("[TB] continuous fetch requests");
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h40;
        rvcount = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (bus.if_gnt_o) gl.push_back(i);
            if (bus.if_rvalid_o) rvcount++;
        end
        @(posedge clk);
        #1;
        bus.if_req_i = 1'b0;
        checkOutput("stream_grants", 32'(gl.size()), 32'd5);
        for (int k = 0; k < gl.size() && k < 5; k++)
            checkOutput("stream_grant_cycle", 32'(gl[k]), 32'(3 * k));
        checkOutput("stream_rvalids", 32'(rvcount), 32'd4);
        waitRvalid(1'b1, r);
        checkOutput("stream_rdata", bus.if_rdata_o, 32'h0080_0193);
        idleCycles(2);

        $display("[TB] reset in the cycle after a grant");
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, g);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_mem_req",   32'(bus.mem_req_o),   32'd0);
        checkOutput("midrst_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
        checkOutput("midrst_if_rdata",  bus.if_rdata_o,       32'd0);
        checkOutput("midrst_dm_rdata",  bus.dm_rdata_o,       32'd0);
        checkOutput("midrst_state",     32'(u_dut.state_q),   32'(ARB_IDLE));
        idleCycles(2);
        rst = 1'b0;
        rvcount = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.if_rvalid_o || bus.dm_rvalid_o) rvcount++;
        end
        checkOutput("midrst_no_rvalid", 32'(rvcount), 32'd0);
        idleCycles(1);
        start = cyc;
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, g);
        checkOutput("postrst_immediate_gnt", 32'(g - start), 32'd0);
        waitRvalid(1'b1, r);
        idleCycles(2);

        $display("[TB] latency-1 instance");
        bus1.if_req_i    = 1'b1;
        bus1.if_addr_i   = 32'h20;
        bus1.mem_rdata_i = 32'hBAD0_0BAD;
        @(negedge clk);
        checkOutput("l1_gnt",      32'(bus1.if_gnt_o),  32'd1);
        checkOutput("l1_mem_req",  32'(bus1.mem_req_o), 32'd1);
        checkOutput("l1_mem_addr", bus1.mem_addr_o,     32'h20);
        @(posedge clk);
        #1;
        bus1.if_req_i    = 1'b0;
        bus1.mem_rdata_i = 32'h0000_1234;
        @(negedge clk);
        checkOutput("l1_no_early_rvalid", 32'(bus1.if_rvalid_o), 32'd0);
        @(posedge clk);
        #1;
        bus1.mem_rdata_i = 32'hBAD1_1BAD;
        @(negedge clk);
        checkOutput("l1_rvalid", 32'(bus1.if_rvalid_o), 32'd1);
        checkOutput("l1_rdata",  bus1.if_rdata_o,       32'h0000_1234);
        @(posedge clk);
        #1;
        bus1.mem_rdata_i = 32'hBAD2_2BAD;
        @(negedge clk);
        checkOutput("l1_rvalid_pulse", 32'(bus1.if_rvalid_o), 32'd0);
        checkOutput("l1_rdata_hold",   bus1.if_rdata_o,       32'h0000_1234);
        idleCycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
